fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Sequences instruction fetch for one core. Drives the PC and read strobe of a synchronous instruction memory.
//  Buffers returned words with their PCs in a small FIFO and presents them to the instruction decoder
//  over a valid/ready handshake. Supports start, halt-with-drain and branch redirect with flush of stale fetches.
// PARAMETERS
//  DATAPATH_WIDTH   64  width of instruction memory word / instruction bus
//  INST_ADDR_WIDTH  9   PC / instruction memory word-address width
//  FIFO_DEPTH       4   fetch buffer entries; power of two, >=2; also the max outstanding-plus-buffered credit limit
// PORTS
//  clk             in   1                clock, all state on rising edge
//  rst_n           in   1                asynchronous, active-low reset
//  start           in   1                pulse; begin fetching at start_pc (honoured in IDLE only)
//  start_pc        in   INST_ADDR_WIDTH  first fetch address
//  halt            in   1                pulse; stop issuing, drain buffer, return to IDLE (honoured in RUN only)
//  redirect_valid  in   1                branch/jump taken; flush and refetch from redirect_pc (RUN only)
//  redirect_pc     in   INST_ADDR_WIDTH  redirect target
//  imem_rd_en      out  1                instruction memory read strobe
//  imem_addr       out  INST_ADDR_WIDTH  instruction memory address (= current PC)
//  imem_rdata      in   DATAPATH_WIDTH   read data, valid exactly 1 cycle after imem_rd_en
//  inst_out        out  DATAPATH_WIDTH   FIFO head instruction to decoder
//  pc_out          out  INST_ADDR_WIDTH  PC of inst_out
//  inst_valid      out  1                FIFO head valid
//  inst_ready      in   1                decoder accepts; transfer when inst_valid && inst_ready
//  busy            out  1                state != IDLE
//  state_out       out  2                FSM state: 0 IDLE, 1 RUN, 2 DRAIN
// BEHAVIOUR
//  - Reset (rst_n low, async): state IDLE, pc 0, FIFO empty, in-flight 0.
//    All outputs 0 (imem_rd_en, imem_addr, inst_out, pc_out, inst_valid, busy, state_out).
//  - FSM: IDLE --start--> RUN (pc<=start_pc). RUN --halt--> DRAIN. DRAIN --(count==0 && inflight==0)--> IDLE.
//    start outside IDLE ignored. halt outside RUN ignored. start and halt together in IDLE: start taken, halt ignored.
//  - Issue: imem_rd_en = (state==RUN) && !redirect_valid && (count + inflight < FIFO_DEPTH), using registered count/inflight.
//    imem_addr = pc. On issue, pc <= pc+1, wrapping modulo 2**INST_ADDR_WIDTH (max -> 0).
//  - inflight (1 bit): set on issue, cleared the next cycle. The returned imem_rdata is pushed into the FIFO together
//    with the PC it was issued for, unless killed.
//  - Latency: rd_en at cycle t -> data pushed at end of t+1 -> inst_valid at t+2. Start sampled at cycle 0 ->
//    first rd_en cycle 1 -> first inst_valid cycle 3. With inst_ready held high: one instruction per cycle sustained.
//  - FIFO: inst_valid = count!=0. Push and pop in the same cycle is legal; count unchanged.
//    Push can never arrive when full (guaranteed by the credit rule).
//  - Redirect (RUN only): pc <= redirect_pc. FIFO flushed (count<=0). Any in-flight response is killed (not pushed).
//    No read is issued in the redirect cycle. Fetch resumes the next cycle at redirect_pc.
//    A handshake in the same cycle as the redirect completes normally; that instruction is the last pre-redirect one.
//  - Redirect + halt in the same cycle: flush applies and state goes to DRAIN, then IDLE once in-flight clears.
//  - DRAIN: no new reads. The in-flight response is still pushed. Buffered entries are delivered in order.
//  - Ordering: instructions are delivered strictly in issue order. No duplicates and no drops except those
//    flushed by a redirect.
//  - busy and state_out are registered from state.
// TESTING
//  1 Reset: assert rst_n=0 mid-RUN with FIFO holding 3 entries.
//    -> inst_valid, imem_rd_en, busy, pc_out all 0 immediately (no clock edge needed).
//  2 Stream+wrap: start_pc=0x1FD, inst_ready=1, imem model returns {55'h0,addr}.
//    -> inst_valid first at cycle 3, then back-to-back pc_out 0x1FD, 0x1FE, 0x1FF, 0x000, 0x001 with matching inst_out.
//  3 Backpressure: inst_ready=0 for 10 cycles in RUN.
//    -> exactly 4 reads issued, then imem_rd_en=0. On release, 4 entries drain in order, then streaming resumes without gaps.
//  4 Redirect: redirect_valid with redirect_pc=0x040 while FIFO holds 2 entries and 1 read is in flight.
//    -> next delivered pc_out=0x040; no stale pc delivered; no rd_en in the redirect cycle.
//  5 Halt: halt with 3 buffered + 1 in flight, inst_ready=1.
//    -> 4 more handshakes, then busy=0 and state_out=0 the next cycle; start/halt ignored appropriately per FSM rules.
//  6 Simultaneous: redirect+halt same cycle -> no further pushes; IDLE within 2 cycles.
//    Push+pop with count=FIFO_DEPTH-1 -> count unchanged.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues PC-ordered reads to a synchronous imem, buffers
// returned words with their PCs and hands them to the decoder over valid/ready.
module fetch_sequencer #(
  parameter int unsigned DATAPATH_WIDTH  = 64,
  parameter int unsigned INST_ADDR_WIDTH = 9,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [INST_ADDR_WIDTH-1:0] start_pc,
  input  logic                       halt,
  input  logic                       redirect_valid,
  input  logic [INST_ADDR_WIDTH-1:0] redirect_pc,
  output logic                       imem_rd_en,
  output logic [INST_ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATAPATH_WIDTH-1:0]  imem_rdata,
  output logic [DATAPATH_WIDTH-1:0]  inst_out,
  output logic [INST_ADDR_WIDTH-1:0] pc_out,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic                       busy,
  output logic [1:0]                 state_out
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [INST_ADDR_WIDTH-1:0] pc;
    logic [DATAPATH_WIDTH-1:0]  inst;
  } entry_t;

  state_t                     state_q, state_d;
  logic                       busy_q;
  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                       inflight_q;
  logic [INST_ADDR_WIDTH-1:0] inflight_pc_q;
  entry_t                     fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]           count_q;
  logic                       issue, flush, push, pop;
  entry_t                     head;

  // Next-state, PC and issue decision from registered occupancy
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = start_pc;
        end
      end
      RUN: begin
        flush = redirect_valid;
        issue = !redirect_valid &&
                ((count_q + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
        if (redirect_valid) pc_d = redirect_pc;
        else if (issue)     pc_d = pc_q + INST_ADDR_WIDTH'(1);
        if (halt) state_d = DRAIN;
      end
      DRAIN: begin
        if ((count_q == '0) && !inflight_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = inflight_q && !flush;
  assign pop  = inst_valid && inst_ready;
  assign head = fifo_q[rd_ptr_q];

  assign imem_rd_en = issue;
  assign imem_addr  = pc_q;
  assign inst_valid = (count_q != '0);
  assign inst_out   = inst_valid ? head.inst : '0;
  assign pc_out     = inst_valid ? head.pc : '0;
  assign busy       = busy_q;
  assign state_out  = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != IDLE);
      pc_q       <= pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= pc_q;
    end
  end

  // Occupancy tracking; a redirect drops every buffered entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while counted valid
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{pc: inflight_pc_q, inst: imem_rdata};
  end

endmodule
